pe_inject_arbiter: RTL and testbench

Credit-aware injection arbiter between NUM_REQ local traffic sources inside a processing element and the single NoC send port of that PE. It keeps one credit counter per VC and grants requesters round-robin at packet granularity, holding wormhole lock from head to tail. It emits flits in the standard `{valid, tail, dest, vc, data}` format and consumes `{valid, vc}` credit returns from the router.

---
 rtl/pe_inject_arbiter.sv | 150 +++++++++++++++
 tb/tb_pe_inject_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_inject_arbiter.sv
// Credit-aware round-robin injection arbiter: NUM_REQ local sources share
// one NoC send port, with wormhole lock held from head flit to tail flit.
module pe_inject_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int NUM_VCS         = 2,
  parameter int DEST_BITS       = 4,
  parameter int FLIT_DATA_WIDTH = 64,
  parameter int BUF_DEPTH       = 8,
  localparam int VC_BITS  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int CNT_W    = $clog2(BUF_DEPTH + 1),
  localparam int FLIT_W   = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH,
  localparam int CREDIT_W = 1 + VC_BITS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0]                   req_tail,
  input  logic [NUM_REQ*DEST_BITS-1:0]         req_dest,
  input  logic [NUM_REQ*VC_BITS-1:0]           req_vc,
  input  logic [NUM_REQ*FLIT_DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [FLIT_W-1:0]                    flit_out,
  output logic                                 sendFlit,
  input  logic [CREDIT_W-1:0]                  credit_in,
  output logic [NUM_VCS-1:0]                   vc_blocked,
  output logic                                 credit_err
);

  localparam int RW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e               state_q, state_d;
  logic [RW-1:0]        owner_q, owner_d;
  logic [RW-1:0]        rr_q, rr_d;
  logic [VC_BITS-1:0]   lvc_q, lvc_d;
  logic [CNT_W-1:0]     cred_q [NUM_VCS];
  logic [CNT_W-1:0]     cred_d [NUM_VCS];
  logic                 err_q, err_d;
  logic [NUM_VCS-1:0]   blk_q, blk_d;
  logic [FLIT_W-1:0]    flit_q, flit_d;

  logic                 xfer;
  logic [RW-1:0]        gnt;
  logic [RW-1:0]        idx;
  logic [VC_BITS-1:0]   fvc;
  logic [VC_BITS-1:0]   hvc;
  logic [NUM_REQ-1:0]   ready;
  logic [NUM_VCS-1:0]   inc, dec;

  // Grant selection: owner only while locked, else round-robin from rr_q.
  always_comb begin
    xfer  = 1'b0;
    gnt   = '0;
    idx   = '0;
    ready = '0;
    if (rst_n && en) begin
      if (state_q == LOCKED) begin
        if (req_valid[owner_q] && cred_q[lvc_q] != '0) begin
          xfer = 1'b1;
          gnt  = owner_q;
        end
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          idx = RW'((int'(rr_q) + i) % NUM_REQ);
          if (!xfer && req_valid[idx] &&
              cred_q[req_vc[int'(idx)*VC_BITS +: VC_BITS]] != '0) begin
            xfer = 1'b1;
            gnt  = idx;
          end
        end
      end
    end
    if (xfer) ready[gnt] = 1'b1;
    hvc = req_vc[int'(gnt)*VC_BITS +: VC_BITS];
    fvc = (state_q == LOCKED) ? lvc_q : hvc;
  end

  // Next state: flit register, credit counters, lock and pointer.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    lvc_d   = lvc_q;
    err_d   = err_q;
    cred_d  = cred_q;
    blk_d   = '0;
    inc     = '0;
    dec     = '0;
    flit_d  = '0;
    if (xfer) begin
      flit_d = {1'b1, req_tail[gnt],
                req_dest[int'(gnt)*DEST_BITS +: DEST_BITS], fvc,
                req_data[int'(gnt)*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH]};
    end
    for (int v = 0; v < NUM_VCS; v++) begin
      inc[v] = credit_in[CREDIT_W-1] &&
               credit_in[VC_BITS-1:0] == VC_BITS'(v);
      dec[v] = xfer && fvc == VC_BITS'(v);
      if (inc[v] && !dec[v]) begin
        if (cred_q[v] == CNT_W'(BUF_DEPTH)) err_d = 1'b1;
        else cred_d[v] = cred_q[v] + 1'b1;
      end else if (dec[v] && !inc[v]) begin
        cred_d[v] = cred_q[v] - 1'b1;
      end
      blk_d[v] = (cred_d[v] == '0);
    end
    if (xfer) begin
      if (req_tail[gnt]) begin
        state_d = IDLE;
        rr_d    = (gnt == RW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
      end else if (state_q == IDLE) begin
        state_d = LOCKED;
        owner_d = gnt;
        lvc_d   = hvc;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      lvc_q   <= '0;
      err_q   <= 1'b0;
      blk_q   <= '0;
      flit_q  <= '0;
      for (int v = 0; v < NUM_VCS; v++) cred_q[v] <= CNT_W'(BUF_DEPTH);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      lvc_q   <= lvc_d;
      err_q   <= err_d;
      blk_q   <= blk_d;
      flit_q  <= flit_d;
      cred_q  <= cred_d;
    end
  end

  assign req_ready  = ready;
  assign flit_out   = flit_q;
  assign sendFlit   = flit_q[FLIT_W-1];
  assign vc_blocked = blk_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_pe_inject_arbiter.sv
// Randomized bench for pe_inject_arbiter with a packet-level model of
// credits, wormhole lock and round-robin order, plus directed scenarios.
module tb_pe_inject_arbiter;

  localparam int NR = 4;
  localparam int NV = 2;
  localparam int DB = 4;
  localparam int DW = 64;
  localparam int BD = 8;
  localparam int VB = 1;
  localparam int FW = 2 + DB + VB + DW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_tail;
  logic [NR*DB-1:0] req_dest;
  logic [NR*VB-1:0] req_vc;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [FW-1:0]   flit_out;
  logic            sendFlit;
  logic [VB:0]     credit_in;
  logic [NV-1:0]   vc_blocked;
  logic            credit_err;

  pe_inject_arbiter #(
    .NUM_REQ(NR), .NUM_VCS(NV), .DEST_BITS(DB),
    .FLIT_DATA_WIDTH(DW), .BUF_DEPTH(BD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_tail(req_tail),
    .req_dest(req_dest), .req_vc(req_vc), .req_data(req_data),
    .req_ready(req_ready), .flit_out(flit_out), .sendFlit(sendFlit),
    .credit_in(credit_in), .vc_blocked(vc_blocked),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state
  int            m_cred [NV];
  bit            m_locked;
  int            m_owner;
  int            m_lvc;
  int            m_rr;
  int            m_g;
  logic [FW-1:0] m_flit;
  logic          m_err;
  logic [NV-1:0] m_blk;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic int vc_of(input int r);
    return int'(req_vc[r*VB +: VB]);
  endfunction

  // Who must be granted now, from the arbitration rules.
  function automatic int grant();
    if (!rst_n || !en) return -1;
    if (m_locked)
      return (req_valid[m_owner] && m_cred[m_lvc] > 0) ? m_owner : -1;
    for (int i = 0; i < NR; i++) begin
      int r;
      r = (m_rr + i) % NR;
      if (req_valid[r] && m_cred[vc_of(r)] > 0) return r;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) m_cred[v] = BD;
    m_locked = 0; m_owner = 0; m_lvc = 0; m_rr = 0; m_g = -1;
    m_flit = '0; m_err = 1'b0; m_blk = '0;
  endtask

  task automatic model_edge();
    int g, cv, rv;
    logic [VB-1:0] vl;
    if (!rst_n) begin
      model_reset();
      return;
    end
    g = grant();
    m_g = g;
    cv = -1;
    m_flit = '0;
    if (g >= 0) begin
      cv = m_locked ? m_lvc : vc_of(g);
      vl = VB'(cv);
      m_flit = {1'b1, req_tail[g], req_dest[g*DB +: DB], vl,
                req_data[g*DW +: DW]};
    end
    rv = credit_in[VB] ? int'(credit_in[VB-1:0]) : -1;
    if (!(rv >= 0 && rv == cv)) begin
      if (cv >= 0) m_cred[cv]--;
      if (rv >= 0) begin
        if (m_cred[rv] == BD) m_err = 1'b1;
        else m_cred[rv]++;
      end
    end
    if (g >= 0) begin
      if (req_tail[g]) begin
        m_locked = 0;
        m_rr = (g + 1) % NR;
      end else if (!m_locked) begin
        m_locked = 1;
        m_owner = g;
        m_lvc = vc_of(g);
      end
    end
    for (int v = 0; v < NV; v++) m_blk[v] = (m_cred[v] == 0);
  endtask

  // Called at a falling edge with inputs set; compares, clocks, advances.
  task automatic step();
    int g;
    logic [NR-1:0] er;
    #1;
    g = grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("ready", req_ready, er);
    chk("flit", flit_out, m_flit);
    chk("send", sendFlit, m_flit[FW-1]);
    chk("blocked", vc_blocked, m_blk);
    chk("err", credit_err, m_err);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Random requester generator state
  bit pend [NR];
  int rem  [NR];
  int pvc  [NR];

  logic [FW-1:0] lit;
  int cnt;

  initial begin
    rst_n = 1'b0; en = 1'b1;
    req_valid = '0; req_tail = '0; req_dest = '0;
    req_vc = '0; req_data = '0; credit_in = '0;
    model_reset();
    @(negedge clk);
    step();
    #1 chk("rst_ready", req_ready, 0);
    step();
    chk("rst_flit", flit_out, 0);
    chk("rst_blk", vc_blocked, 0);
    chk("rst_err", credit_err, 0);
    rst_n = 1'b1;

    // Two single-flit packets on vc0
    req_valid = 4'b0101; req_tail = 4'b0101; req_vc = '0;
    #1 chk("t1_r0", req_ready, 4'b0001);
    step();
    req_valid = 4'b0100;
    #1 chk("t1_r2", req_ready, 4'b0100);
    chk("t1_send0", sendFlit, 1);
    step();
    req_valid = '0;
    chk("t1_send1", sendFlit, 1);
    chk("t1_cred", m_cred[0], 6);
    step();
    chk("t1_send2", sendFlit, 0);

    // r1 three-flit packet on vc1, others contend
    req_valid = 4'b0010; req_tail = '0; req_vc = 4'b0010;
    req_dest[7:4] = 4'h5; req_data[127:64] = 64'hA1;
    #1 chk("t2_h", req_ready, 4'b0010);
    step();
    req_valid = 4'b1011; req_tail = 4'b1001; req_vc = '0;
    #1 chk("t2_b", req_ready, 4'b0010);
    step();
    req_tail = 4'b1011;
    #1 chk("t2_t", req_ready, 4'b0010);
    step();
    lit = {1'b1, 1'b1, 4'h5, 1'b1, 64'hA1};
    chk("t2_flit", flit_out, lit);
    req_valid = 4'b1001;
    #1 chk("t2_r3", req_ready, 4'b1000);
    step();
    req_valid = 4'b0001;
    #1 chk("t2_r0", req_ready, 4'b0001);
    step();
    req_valid = '0;
    step();

    // Exhaust vc0 credits, then one credit frees one flit
    do_reset();
    req_valid = 4'b0001; req_tail = '0; req_vc = '0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      req_data[63:0] = 64'(i);
      step();
      if (m_g == 0) cnt++;
    end
    chk("t3_cnt", cnt, 8);
    chk("t3_blk", vc_blocked, 2'b01);
    #1 chk("t3_rdy", req_ready, 0);
    credit_in = 2'b10;
    step();
    credit_in = '0;
    #1 chk("t3_rdy1", req_ready, 4'b0001);
    step();
    chk("t3_send", sendFlit, 1);

    // Return and consume on vc0 in the same cycle at count 3
    do_reset();
    for (int i = 0; i < 5; i++) step();
    chk("t4_c3", m_cred[0], 3);
    credit_in = 2'b10;
    step();
    credit_in = '0;
    chk("t4_hold", m_cred[0], 3);
    chk("t4_err", credit_err, 0);
    for (int i = 0; i < 3; i++) step();
    chk("t4_blk", vc_blocked, 2'b01);
    #1 chk("t4_rdy", req_ready, 0);

    // Credit overflow on vc1 is sticky until reset
    do_reset();
    req_valid = '0;
    credit_in = 2'b11;
    step();
    credit_in = '0;
    chk("t5_err", credit_err, 1);
    step(); step();
    chk("t5_sticky", credit_err, 1);
    do_reset();
    chk("t5_clr", credit_err, 0);

    // en drop mid-packet of r2, then reset
    req_valid = 4'b0100; req_tail = '0; req_vc = 4'b0100;
    step(); step();
    en = 1'b0;
    req_valid = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_nosend", sendFlit, 0);
    end
    #1 chk("t6_rdy", req_ready, 0);
    en = 1'b1;
    rst_n = 1'b0;
    step();
    chk("t6_flit", flit_out, 0);
    chk("t6_blk", vc_blocked, 0);
    rst_n = 1'b1;
    #1 chk("t6_idle", req_ready, 4'b0001);
    step();
    req_valid = '0;
    step();

    // Randomized traffic
    do_reset();
    for (int r = 0; r < NR; r++) begin
      pend[r] = 0; rem[r] = 0; pvc[r] = 0;
    end
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom % 400 != 0);
      en = ($urandom % 10 != 0);
      for (int r = 0; r < NR; r++) begin
        if (!pend[r] && $urandom % 3 == 0) begin
          int v;
          pend[r] = 1;
          if (rem[r] == 0) begin
            rem[r] = 1 + $urandom % 4;
            pvc[r] = $urandom % NV;
            v = pvc[r];
          end else begin
            v = $urandom % NV;
          end
          req_tail[r] = (rem[r] == 1);
          req_vc[r*VB +: VB] = VB'(v);
          req_dest[r*DB +: DB] = DB'($urandom);
          req_data[r*DW +: DW] = {$urandom, $urandom};
        end
        req_valid[r] = pend[r];
      end
      credit_in = '0;
      if ($urandom % 5 < 2) begin
        int v;
        v = $urandom % NV;
        if (m_cred[v] < BD || $urandom % 200 == 0)
          credit_in = {1'b1, VB'(v)};
      end
      step();
      if (!rst_n) begin
        for (int r = 0; r < NR; r++) begin
          pend[r] = 0; rem[r] = 0;
        end
      end else if (m_g >= 0) begin
        pend[m_g] = 0;
        rem[m_g]--;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
